// File: rtl/indicator_sequencer_pkg.sv
// car_light_pkg: shared definitions for the turn-indicator sequencer.
//   SEL_*   : encoding of the exterior-light select bus (0 off, 1 right,
//             2 left, 3 hazard)
//   state_t : sequencer states; COMFORT_L/COMFORT_R exist only when
//             INDICATOR_COMFORT_BLINK_EN is defined
//   sel_of  : state -> exterior-light select decode
package car_light_pkg;

    localparam logic [0:1] SEL_OFF    = 2'd0;
    localparam logic [0:1] SEL_RIGHT  = 2'd1;
    localparam logic [0:1] SEL_LEFT   = 2'd2;
    localparam logic [0:1] SEL_HAZARD = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LEFT      = 3'd1,
        RIGHT     = 3'd2,
`ifdef INDICATOR_COMFORT_BLINK_EN
        COMFORT_L = 3'd3,
        COMFORT_R = 3'd4,
`endif
        HAZARD    = 3'd5
    } state_t;

    function automatic logic [0:1] sel_of(input state_t s);
        case (s)
            LEFT:      return SEL_LEFT;
            RIGHT:     return SEL_RIGHT;
`ifdef INDICATOR_COMFORT_BLINK_EN
            COMFORT_L: return SEL_LEFT;
            COMFORT_R: return SEL_RIGHT;
`endif
            HAZARD:    return SEL_HAZARD;
            default:   return SEL_OFF;
        endcase
    endfunction

endpackage

// File: rtl/indicator_sequencer_if.sv
// indicator_sequencer_if: driver-controls / lamp-outputs bundle.
//   stalk_left, stalk_right, hazard_btn : debounced synchronous levels in
//   sel_ext [0:1]                       : exterior-light select out
//   flash                               : blink waveform out
//   tick                                : one-cycle pulse on flash rising
// master = the controls/lamp side, slave = the sequencer.
interface indicator_sequencer_if;
    logic       stalk_left;
    logic       stalk_right;
    logic       hazard_btn;
    logic [0:1] sel_ext;
    logic       flash;
    logic       tick;

    modport master (
        output stalk_left, stalk_right, hazard_btn,
        input  sel_ext, flash, tick
    );

    modport slave (
        input  stalk_left, stalk_right, hazard_btn,
        output sel_ext, flash, tick
    );
endinterface

// File: rtl/indicator_sequencer_flash_timer.sv
// flash_timer: blink phase generator.
//   clk, rst    : clock, asynchronous active-high reset
//   i_run       : sequencer will be in a non-idle state next cycle
//   i_restart   : start a fresh blink (flash=1, tick=1 next cycle)
//   o_flash     : registered blink waveform, HALF_PERIOD cycles per phase
//   o_tick      : registered one-cycle pulse on each flash 0->1
//   o_ons       : completed on-phases, saturating at COMFORT_FLASHES
//   o_phase_end : current cycle is the last of the current phase
module flash_timer #(
    parameter int unsigned HALF_PERIOD     = 4,
    parameter int unsigned COMFORT_FLASHES = 3,
    localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1,
    localparam int unsigned OW = $clog2(COMFORT_FLASHES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_run,
    input  logic          i_restart,
    output logic          o_flash,
    output logic          o_tick,
    output logic [OW-1:0] o_ons,
    output logic          o_phase_end
);

    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [OW-1:0] ONS_MAX    = OW'(COMFORT_FLASHES);

    logic [PW-1:0] r_phase;
    logic          r_flash;
    logic          r_tick;
    logic [OW-1:0] r_ons;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_flash <= 1'b0;
            r_tick  <= 1'b0;
            r_ons   <= '0;
        end else if (!i_run) begin
            r_phase <= '0;
            r_flash <= 1'b0;
            r_tick  <= 1'b0;
            r_ons   <= '0;
        end else if (i_restart) begin
            r_phase <= '0;
            r_flash <= 1'b1;
            r_tick  <= 1'b1;
            r_ons   <= '0;
        end else if (r_phase == PHASE_LAST) begin
            r_phase <= '0;
            r_flash <= ~r_flash;
            // Leaving an off-phase is exactly a 0->1 flash transition.
            r_tick  <= ~r_flash;
            if (r_flash && (r_ons != ONS_MAX))
                r_ons <= r_ons + 1'b1;
        end else begin
            r_phase <= r_phase + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    assign o_flash     = r_flash;
    assign o_tick      = r_tick;
    assign o_ons       = r_ons;
    assign o_phase_end = (r_phase == PHASE_LAST);

endmodule

// File: rtl/indicator_sequencer.sv
// indicator_sequencer: turn-indicator / hazard sequencer.
//   clk : system clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : indicator_sequencer_if.slave (stalks and hazard button in,
//         sel_ext / flash / tick out, all outputs registered)
// Optional feature: define INDICATOR_COMFORT_BLINK_EN to enable comfort
// blinking (a short stalk tap completes COMFORT_FLASHES flashes).
module indicator_sequencer
    import car_light_pkg::*;
#(
    parameter int unsigned HALF_PERIOD     = 4,
    parameter int unsigned TAP_CYCLES      = 16,
    parameter int unsigned COMFORT_FLASHES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    indicator_sequencer_if.slave  bus
);

    localparam int unsigned OW = $clog2(COMFORT_FLASHES + 1);

    state_t        r_state;
    state_t        w_next;
    logic [0:1]    r_sel;
    logic          r_haz;
    logic          r_btn_prev;
    logic          r_btn_armed;

    logic          w_stalk_l;
    logic          w_stalk_r;
    logic          w_btn_edge;
    logic          w_haz_next;
    logic          w_run;
    logic          w_restart;
    logic          w_flash;
    logic          w_tick;
    logic          w_phase_end;
    logic [OW-1:0] w_ons;

    // Both stalks high is an invalid combination and reads as neither.
    assign w_stalk_l = bus.stalk_left  & ~bus.stalk_right;
    assign w_stalk_r = bus.stalk_right & ~bus.stalk_left;

    // r_btn_armed only sets once the button has been seen low after reset,
    // so a button held through reset release cannot produce an edge.
    assign w_btn_edge = bus.hazard_btn & ~r_btn_prev & r_btn_armed;
    assign w_haz_next = r_haz ^ w_btn_edge;

`ifdef INDICATOR_COMFORT_BLINK_EN
    localparam int unsigned   HW       = $clog2(TAP_CYCLES + 2);
    localparam logic [HW-1:0] HOLD_TAP = HW'(TAP_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(TAP_CYCLES + 1);
    localparam logic [OW-1:0] ONS_MAX  = OW'(COMFORT_FLASHES);

    logic [HW-1:0] r_hold;
    logic          w_comfort_done;

    assign w_comfort_done = w_phase_end & ~w_flash & (w_ons == ONS_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_hold <= '0;
        else if ((w_next == LEFT) || (w_next == RIGHT)) begin
            if (w_next != r_state)
                r_hold <= HW'(1);
            else if (r_hold != HOLD_MAX)
                r_hold <= r_hold + 1'b1;
        end else
            r_hold <= '0;
    end
`else
    logic w_unused;
    assign w_unused = w_phase_end ^ (^w_ons) ^ (TAP_CYCLES > 0);
`endif

    always_comb begin
        w_next    = IDLE;
        w_restart = 1'b0;
        if (w_haz_next)
            w_next = HAZARD;
        else if (w_stalk_l)
            w_next = LEFT;
        else if (w_stalk_r)
            w_next = RIGHT;
        else begin
            case (r_state)
`ifdef INDICATOR_COMFORT_BLINK_EN
                LEFT:      if ((r_hold <= HOLD_TAP) && (w_ons < ONS_MAX)) w_next = COMFORT_L;
                RIGHT:     if ((r_hold <= HOLD_TAP) && (w_ons < ONS_MAX)) w_next = COMFORT_R;
                COMFORT_L: if (!w_comfort_done) w_next = COMFORT_L;
                COMFORT_R: if (!w_comfort_done) w_next = COMFORT_R;
`endif
                default:   w_next = IDLE;
            endcase
        end
        w_restart = (w_next != IDLE) && (w_next != r_state);
`ifdef INDICATOR_COMFORT_BLINK_EN
        // Tap release carries the running blink into comfort unchanged.
        if (((r_state == LEFT) && (w_next == COMFORT_L)) ||
            ((r_state == RIGHT) && (w_next == COMFORT_R)))
            w_restart = 1'b0;
`endif
    end

    assign w_run = (w_next != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= SEL_OFF;
            r_haz       <= 1'b0;
            r_btn_prev  <= 1'b0;
            r_btn_armed <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_sel       <= sel_of(w_next);
            r_haz       <= w_haz_next;
            r_btn_prev  <= bus.hazard_btn;
            r_btn_armed <= r_btn_armed | ~bus.hazard_btn;
        end
    end

    flash_timer #(
        .HALF_PERIOD     (HALF_PERIOD),
        .COMFORT_FLASHES (COMFORT_FLASHES)
    ) u_flash_timer (
        .clk         (clk),
        .rst         (rst),
        .i_run       (w_run),
        .i_restart   (w_restart),
        .o_flash     (w_flash),
        .o_tick      (w_tick),
        .o_ons       (w_ons),
        .o_phase_end (w_phase_end)
    );

    assign bus.sel_ext = r_sel;
    assign bus.flash   = w_flash;
    assign bus.tick    = w_tick;

endmodule

// File: tb/tb_indicator_sequencer.sv
// tb_indicator_sequencer: directed bench for indicator_sequencer with
// HALF_PERIOD=4, TAP_CYCLES=16, COMFORT_FLASHES=3. Expected comfort
// behaviour follows INDICATOR_COMFORT_BLINK_EN.
module tb_indicator_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    indicator_sequencer_if bus ();

    indicator_sequencer #(
        .HALF_PERIOD     (4),
        .TAP_CYCLES      (16),
        .COMFORT_FLASHES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Blink pattern for cycle n (1-based) after a fresh entry, half-period 4.
    function automatic logic exp_flash(input int n);
        return ((n - 1) % 8) < 4;
    endfunction

    function automatic logic exp_tick(input int n);
        return ((n - 1) % 8) == 0;
    endfunction

`ifdef INDICATOR_COMFORT_BLINK_EN
    int tap_len [4] = '{1, 6, 16, 17};
    int tap_act [4] = '{24, 24, 24, 17};
`else
    int tap_len [4] = '{1, 6, 16, 17};
    int tap_act [4] = '{1, 6, 16, 17};
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.stalk_left  = 1'b0;
        bus.stalk_right = 1'b0;
        bus.hazard_btn  = 1'b0;
        #12;
        chk("rst_sel", bus.sel_ext, 0);
        chk("rst_flash", bus.flash, 0);
        chk("rst_tick", bus.tick, 0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("idle_sel", bus.sel_ext, 0);

        // Long left hold: steady blink, release goes straight to IDLE.
        bus.stalk_left = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            chk($sformatf("left_sel_c%0d", n), bus.sel_ext, 2);
            chk($sformatf("left_flash_c%0d", n), bus.flash, exp_flash(n));
            chk($sformatf("left_tick_c%0d", n), bus.tick, exp_tick(n));
        end
        bus.stalk_left = 1'b0;
        step();
        chk("left_rel_sel", bus.sel_ext, 0);
        chk("left_rel_flash", bus.flash, 0);
        step();

        // Right taps of various lengths around the tap threshold.
        for (int t = 0; t < 4; t++) begin
            bus.stalk_right = 1'b1;
            for (int n = 1; n <= 30; n++) begin
                step();
                if (n == tap_len[t]) bus.stalk_right = 1'b0;
                chk($sformatf("tap%0d_sel_c%0d", tap_len[t], n), bus.sel_ext,
                    (n <= tap_act[t]) ? 1 : 0);
                chk($sformatf("tap%0d_flash_c%0d", tap_len[t], n), bus.flash,
                    (n <= tap_act[t]) ? exp_flash(n) : 1'b0);
            end
        end

        // New stalk after a tap takes over with a fresh blink.
        bus.stalk_right = 1'b1;
        for (int n = 1; n <= 6; n++) step();
        bus.stalk_right = 1'b0;
        for (int n = 7; n <= 9; n++) step();
        bus.stalk_left = 1'b1;
        step();
        chk("preempt_sel", bus.sel_ext, 2);
        chk("preempt_flash", bus.flash, 1);
        chk("preempt_tick", bus.tick, 1);
        step();
        chk("preempt_tick2", bus.tick, 0);
        for (int n = 3; n <= 20; n++) step();
        bus.stalk_left = 1'b0;
        step();
        chk("preempt_rel_sel", bus.sel_ext, 0);
        step();

        // Hazard on/off while left is held, then a left->right swap.
        bus.stalk_left = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk($sformatf("hz_left_sel_c%0d", n), bus.sel_ext, 2);
        end
        bus.hazard_btn = 1'b1;
        step();
        bus.hazard_btn = 1'b0;
        chk("hz_on_sel", bus.sel_ext, 3);
        chk("hz_on_flash", bus.flash, 1);
        chk("hz_on_tick", bus.tick, 1);
        for (int n = 2; n <= 8; n++) begin
            step();
            chk($sformatf("hz_sel_c%0d", n), bus.sel_ext, 3);
            chk($sformatf("hz_flash_c%0d", n), bus.flash, exp_flash(n));
            chk($sformatf("hz_tick_c%0d", n), bus.tick, exp_tick(n));
        end
        bus.hazard_btn = 1'b1;
        step();
        bus.hazard_btn = 1'b0;
        chk("hz_off_sel", bus.sel_ext, 2);
        chk("hz_off_flash", bus.flash, 1);
        chk("hz_off_tick", bus.tick, 1);
        for (int n = 2; n <= 20; n++) begin
            step();
            chk($sformatf("hz_back_flash_c%0d", n), bus.flash, exp_flash(n));
        end
        bus.stalk_left  = 1'b0;
        bus.stalk_right = 1'b1;
        step();
        chk("swap_sel", bus.sel_ext, 1);
        chk("swap_flash", bus.flash, 1);
        chk("swap_tick", bus.tick, 1);
        step();
        chk("swap_tick2", bus.tick, 0);
        for (int n = 3; n <= 20; n++) step();
        bus.stalk_right = 1'b0;
        step();
        chk("swap_rel_sel", bus.sel_ext, 0);
        step();

        // Both stalks high is ignored.
        bus.stalk_left  = 1'b1;
        bus.stalk_right = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            chk($sformatf("both_sel_c%0d", n), bus.sel_ext, 0);
            chk($sformatf("both_flash_c%0d", n), bus.flash, 0);
        end
        bus.stalk_left  = 1'b0;
        bus.stalk_right = 1'b0;
        step();

        // Button held for 100 cycles toggles the latch once.
        bus.hazard_btn = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            step();
            chk($sformatf("hold_sel_c%0d", n), bus.sel_ext, 3);
        end
        bus.hazard_btn = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            chk($sformatf("hold_rel_sel_c%0d", n), bus.sel_ext, 3);
        end
        bus.hazard_btn = 1'b1;
        step();
        bus.hazard_btn = 1'b0;
        chk("hold_off_sel", bus.sel_ext, 0);
        chk("hold_off_flash", bus.flash, 0);
        step();

        // Asynchronous reset mid-hazard, button held across release.
        bus.hazard_btn = 1'b1;
        step();
        bus.hazard_btn = 1'b0;
        chk("ar_haz_sel", bus.sel_ext, 3);
        step();
        step();
        bus.hazard_btn = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("ar_sel", bus.sel_ext, 0);
        chk("ar_flash", bus.flash, 0);
        chk("ar_tick", bus.tick, 0);
        step();
        step();
        #2;
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            chk($sformatf("ar_rel_sel_c%0d", n), bus.sel_ext, 0);
            chk($sformatf("ar_rel_flash_c%0d", n), bus.flash, 0);
        end
        bus.hazard_btn = 1'b0;
        step();
        step();
        bus.hazard_btn = 1'b1;
        step();
        bus.hazard_btn = 1'b0;
        chk("ar_press_sel", bus.sel_ext, 3);
        chk("ar_press_tick", bus.tick, 1);
        step();
        bus.hazard_btn = 1'b1;
        step();
        bus.hazard_btn = 1'b0;
        chk("ar_press2_sel", bus.sel_ext, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/indicator_sequencer.md
INDICATOR_SEQUENCER -- requirements
Module: indicator_sequencer

Interface
REQ-001 Parameter: HALF_PERIOD, 4, clock cycles per flash half-period (on or off); minimum 2.
REQ-002 Parameter: TAP_CYCLES, 16, maximum stalk-held duration (cycles) classed as a tap.
REQ-003 Parameter: COMFORT_FLASHES, 3, total flashes guaranteed after a tap.
REQ-004 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  reset; asynchronous, active-high.
REQ-006 Port: stalk_left  input  1  left stalk level; synchronous, debounced.
REQ-007 Port: stalk_right  input  1  right stalk level; synchronous, debounced.
REQ-008 Port: hazard_btn  input  1  hazard push-button level; synchronous, debounced.
REQ-009 Port: sel_ext  output  [0:1]  downstream exterior-light select: 0 off, 1 right, 2 left, 3 hazard.
REQ-010 Port: flash  output  1  blink waveform; drives the downstream clock-gated lamp input.
REQ-011 Port: tick  output  1  one-cycle pulse on every flash 0->1 transition (chime driver).

Function
REQ-012 States SHALL be IDLE, LEFT, RIGHT, COMFORT_L, COMFORT_R, HAZARD; sel_ext decoded from state: IDLE 0, RIGHT/COMFORT_R 1, LEFT/COMFORT_L 2, HAZARD 3.
REQ-013 All outputs SHALL be registered; input change -> sel_ext/flash update one clock later.
REQ-014 hazard_btn rising edge (registered previous-level compare) SHALL toggle a hazard latch; latch set forces HAZARD from any state.
REQ-015 Priority SHALL be: hazard latch > valid stalk > comfort completion > IDLE.
REQ-016 Both stalks high SHALL be invalid: treated as both low.
REQ-017 IDLE -> LEFT/RIGHT on the corresponding single stalk high; LEFT<->RIGHT direct swap when stalks swap.
REQ-018 On every entry into a non-IDLE state (including swaps and hazard on/off), phase counter SHALL restart: flash=1 and tick=1 in the first output cycle, then flash toggles every HALF_PERIOD cycles.
REQ-019 Hold counter SHALL count cycles in LEFT/RIGHT, saturating at TAP_CYCLES+1; flash counter SHALL count completed on-phases, saturating at COMFORT_FLASHES.
REQ-020 Stalk release with hold <= TAP_CYCLES and flashes < COMFORT_FLASHES SHALL enter COMFORT_L/R without phase restart; otherwise -> IDLE.
REQ-021 COMFORT_x SHALL exit to IDLE at the end of the off-phase following the COMFORT_FLASHES-th on-phase; a new single stalk pre-empts it (fresh entry).
REQ-022 Hazard latch clearing SHALL return to LEFT/RIGHT (fresh entry) if a single stalk is held, else IDLE; comfort state is not resumed.
REQ-023 In IDLE flash=0, tick=0, counters cleared.

Reset
REQ-024 rst high SHALL immediately force state IDLE, sel_ext=0, flash=0, tick=0, hazard latch=0, all counters 0, button-edge register=0, including mid-blink.
REQ-025 A hazard_btn held high across reset release SHALL NOT toggle the latch.

Configuration
REQ-026 Macro INDICATOR_COMFORT_BLINK_EN defined: REQ-020/021 active; undefined: COMFORT_L/R states absent, stalk release always -> IDLE next cycle, TAP_CYCLES and COMFORT_FLASHES unused.

Structure
REQ-027 Package car_light_pkg SHALL hold sel_ext encoding constants (SEL_OFF, SEL_RIGHT, SEL_LEFT, SEL_HAZARD) and the state enumeration.
REQ-028 Sub-module flash_timer SHALL contain the phase counter, flash/tick generation and on-phase counting, with restart input.

Verification (HALF_PERIOD=4, TAP_CYCLES=16, COMFORT_FLASHES=3, macro defined unless stated)
REQ-029 Reset, then stalk_left high 40 cycles -> sel_ext=2 one cycle later, flash 1,1,1,1,0,0,0,0 repeating, tick on cycles 1,9,17,...; release -> sel_ext=0 next cycle.
REQ-030 stalk_right pulsed 6 cycles -> sel_ext=1 for exactly 24 cycles (3 flashes), then 0; same stimulus with macro undefined -> sel_ext=1 for 6 cycles only.
REQ-031 stalk_left held, hazard_btn pulse at cycle 10 -> sel_ext=3, flash restarts at 1; second pulse -> sel_ext=2, flash restarts.
REQ-032 Both stalks high 20 cycles -> sel_ext=0, flash=0 throughout; hazard_btn held 100 cycles -> single toggle only.
REQ-033 rst asserted mid-hazard, off-clock-edge -> sel_ext=0, flash=0 without waiting for clk; hazard_btn high at release -> remains IDLE.
